// File: rtl/distortion_line_scheduler.sv
// distortion_line_scheduler: line-window scheduler gating input writes and output remap rows over a circular line buffer.
// Ports: clk/rst (sync, active high); frame_start_in, in_line_done, out_line_done, err_clr pulses in;
// wr_allow/wr_line_idx (writer gate and slot), rd_go/rd_row (remapper gate and row),
// rd_oldest_row/rd_oldest_idx (oldest resident row and its slot), frame_done, busy, err_flags out.
module distortion_line_scheduler #(
  parameter int WIDTH = 1920,
  parameter int HEIGHT = 1080,
  parameter int BUFFER_LINES = 4,
  parameter int REACH = 1,
  parameter int COORD_WIDTH = 16,
  localparam int IW = $clog2(BUFFER_LINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start_in,
  input  logic                   in_line_done,
  input  logic                   out_line_done,
  input  logic                   err_clr,
  output logic                   wr_allow,
  output logic [IW-1:0]          wr_line_idx,
  output logic                   rd_go,
  output logic [COORD_WIDTH-1:0] rd_row,
  output logic [COORD_WIDTH-1:0] rd_oldest_row,
  output logic [IW-1:0]          rd_oldest_idx,
  output logic                   frame_done,
  output logic                   busy,
  output logic [2:0]             err_flags
);
  localparam int CW = COORD_WIDTH;
  localparam logic [CW:0] H1 = (CW+1)'(HEIGHT);
  localparam logic [CW:0] BL1 = (CW+1)'(BUFFER_LINES);
  localparam logic [CW:0] R1 = (CW+1)'(REACH);
  if (BUFFER_LINES < 2*REACH+1) begin : g_chk_bl
    $error("BUFFER_LINES must be at least 2*REACH+1");
  end
  if (WIDTH < 1) begin : g_chk_w
    $error("WIDTH must be positive");
  end
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;
  state_t state, n_state;
  logic [CW-1:0] lines_in, n_lines, n_oldest, n_row;
  logic [IW-1:0] n_widx, n_oidx;
  logic [CW:0] cand, lim;
  logic [2:0] n_err;
  logic in_acc, out_acc, n_wa, n_go;
  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (i == IW'(BUFFER_LINES-1)) ? '0 : i + 1'b1;
  endfunction
  always_comb begin
    in_acc = in_line_done && state == ACTIVE && wr_allow && ({1'b0, lines_in} < H1);
    out_acc = out_line_done && rd_go;
    n_lines = in_acc ? lines_in + 1'b1 : lines_in;
    n_widx = in_acc ? inc_idx(wr_line_idx) : wr_line_idx;
    n_row = out_acc ? rd_row + 1'b1 : rd_row;
    // Eviction candidate rd_row+1-REACH, floored at 0 and capped at the rows actually written.
    cand = {1'b0, rd_row} + 1'b1;
    cand = (cand >= R1) ? cand - R1 : '0;
    cand = (cand > {1'b0, n_lines}) ? {1'b0, n_lines} : cand;
    n_oldest = (out_acc && cand > {1'b0, rd_oldest_row}) ? cand[CW-1:0] : rd_oldest_row;
    n_oidx = (n_oldest != rd_oldest_row) ? inc_idx(rd_oldest_idx) : rd_oldest_idx;
    n_err = (err_clr ? 3'b000 : err_flags)
          | {out_line_done && !rd_go, in_line_done && !in_acc, frame_start_in && state != IDLE};
    n_state = state;
    if (frame_start_in) begin
      n_state = ACTIVE;
      n_lines = '0;
      n_row = '0;
      n_oldest = '0;
      n_widx = '0;
      n_oidx = '0;
    end else if (state == DONE) begin
      n_state = IDLE;
      n_row = '0;
    end else if (state != IDLE && {1'b0, n_row} == H1) begin
      n_state = DONE;
    end else if (state == ACTIVE && {1'b0, n_lines} == H1) begin
      n_state = DRAIN;
    end
    // Gates are computed from post-update counters so registered outputs track this edge's events.
    lim = {1'b0, n_row} + R1 + 1'b1;
    lim = (lim > H1) ? H1 : lim;
    n_wa = (n_state == IDLE) ? 1'b1 :
           (n_state == ACTIVE) ? ({1'b0, n_lines} < {1'b0, n_oldest} + BL1) : 1'b0;
    n_go = (n_state == ACTIVE || n_state == DRAIN) && ({1'b0, n_lines} >= lim);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lines_in <= '0;
      rd_row <= '0;
      rd_oldest_row <= '0;
      wr_line_idx <= '0;
      rd_oldest_idx <= '0;
      wr_allow <= 1'b0;
      rd_go <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      err_flags <= 3'b000;
    end else begin
      state <= n_state;
      lines_in <= n_lines;
      rd_row <= n_row;
      rd_oldest_row <= n_oldest;
      wr_line_idx <= n_widx;
      rd_oldest_idx <= n_oidx;
      wr_allow <= n_wa;
      rd_go <= n_go;
      frame_done <= n_state == DONE;
      busy <= n_state != IDLE;
      err_flags <= n_err;
    end
  end
endmodule

// File: tb/tb_distortion_line_scheduler.sv
// tb_distortion_line_scheduler: directed vector bench for the line scheduler (HEIGHT=6, BUFFER_LINES=4, REACH=1).
module tb_distortion_line_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic frame_start_in = 1'b0, in_line_done = 1'b0, out_line_done = 1'b0, err_clr = 1'b0;
  logic wr_allow, rd_go, frame_done, busy;
  logic [1:0] wr_line_idx, rd_oldest_idx;
  logic [15:0] rd_row, rd_oldest_row;
  logic [2:0] err_flags;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  distortion_line_scheduler #(.WIDTH(8), .HEIGHT(6), .BUFFER_LINES(4), .REACH(1), .COORD_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .frame_start_in(frame_start_in), .in_line_done(in_line_done),
    .out_line_done(out_line_done), .err_clr(err_clr), .wr_allow(wr_allow), .wr_line_idx(wr_line_idx),
    .rd_go(rd_go), .rd_row(rd_row), .rd_oldest_row(rd_oldest_row), .rd_oldest_idx(rd_oldest_idx),
    .frame_done(frame_done), .busy(busy), .err_flags(err_flags));
  typedef struct packed {
    logic sof, inl, outl, clr;
    logic wa;
    logic [1:0] wi;
    logic go;
    logic [15:0] row, orow;
    logic [1:0] oidx;
    logic fd, busy;
    logic [2:0] err;
  } vec_t;
  vec_t v [25];
  task automatic chk(input string n, input int s, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", n, s, a, e);
    end
  endtask
  task automatic chk_all(input int s, input vec_t e);
    chk("wr_allow", s, int'(wr_allow), int'(e.wa));
    chk("wr_line_idx", s, int'(wr_line_idx), int'(e.wi));
    chk("rd_go", s, int'(rd_go), int'(e.go));
    chk("rd_row", s, int'(rd_row), int'(e.row));
    chk("rd_oldest_row", s, int'(rd_oldest_row), int'(e.orow));
    chk("rd_oldest_idx", s, int'(rd_oldest_idx), int'(e.oidx));
    chk("frame_done", s, int'(frame_done), int'(e.fd));
    chk("busy", s, int'(busy), int'(e.busy));
    chk("err_flags", s, int'(err_flags), int'(e.err));
  endtask
  task automatic step(input logic s, input logic i, input logic o, input logic c);
    frame_start_in = s;
    in_line_done = i;
    out_line_done = o;
    err_clr = c;
    @(posedge clk);
    #1;
    frame_start_in = 1'b0;
    in_line_done = 1'b0;
    out_line_done = 1'b0;
    err_clr = 1'b0;
  endtask
  initial begin
    //         sof in out clr  wa wi go row orow oidx fd busy err
    v[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'd0,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[1]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd1,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[2]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd2,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[3]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd3,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[4]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,2'd0,1'b1,16'd1,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[6]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2'd0,1'b1,16'd2,16'd1,2'd1,1'b0,1'b1,3'd0};
    v[7]  = '{1'b0,1'b1,1'b1,1'b0, 1'b1,2'd1,1'b1,16'd3,16'd2,2'd2,1'b0,1'b1,3'd0};
    v[8]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,2'd2,1'b1,16'd3,16'd2,2'd2,1'b0,1'b1,3'd0};
    v[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,2'd2,1'b1,16'd4,16'd3,2'd3,1'b0,1'b1,3'd0};
    v[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,2'd2,1'b1,16'd5,16'd4,2'd0,1'b0,1'b1,3'd0};
    v[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd2,1'b1,16'd5,16'd4,2'd0,1'b0,1'b1,3'd0};
    v[12] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,2'd2,1'b0,16'd6,16'd5,2'd1,1'b1,1'b1,3'd0};
    v[13] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,2'd2,1'b0,16'd0,16'd5,2'd1,1'b0,1'b0,3'd0};
    v[14] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'd0,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[15] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd1,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[16] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'd0,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd1};
    v[17] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2'd0,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd5};
    v[18] = '{1'b0,1'b0,1'b0,1'b1, 1'b1,2'd0,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[19] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd1,1'b0,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[20] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd2,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[21] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,2'd3,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[22] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    v[23] = '{1'b0,1'b1,1'b0,1'b1, 1'b0,2'd0,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd2};
    v[24] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0,1'b1,16'd0,16'd0,2'd0,1'b0,1'b1,3'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_allow", -1, int'(wr_allow), 0);
    chk("rst_busy", -1, int'(busy), 0);
    chk("rst_rd_go", -1, int'(rd_go), 0);
    chk("rst_err", -1, int'(err_flags), 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all(0, '{1'b0,1'b0,1'b0,1'b0, 1'b1,2'd0,1'b0,16'd0,16'd0,2'd0,1'b0,1'b0,3'd0});
    for (int k = 0; k < 25; k++) begin
      step(v[k].sof, v[k].inl, v[k].outl, v[k].clr);
      chk_all(k + 1, v[k]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_wr_allow", 100, int'(wr_allow), 0);
    chk("midrst_busy", 100, int'(busy), 0);
    chk("midrst_wr_idx", 100, int'(wr_line_idx), 0);
    chk("midrst_rd_go", 100, int'(rd_go), 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_wr_allow", 101, int'(wr_allow), 1);
    chk("post_rst_busy", 101, int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/distortion_line_scheduler.md
# distortion_line_scheduler

Line-window scheduler for the barrel-distortion correction datapath. It tracks which input rows are resident in the circular line buffer and gates the input writer (`wr_allow`) and the output remapper (`rd_go`). Output row r may be produced only once every source row it can reference is stored, and an input row may be written only into a slot that no pending output row still needs. It sits between the AXI4-Stream input writer and the output remap engine, and exports slot-index bookkeeping so the datapath never computes a modulo.

## Interface
- `WIDTH`, 1920: pixels per line (informational; not used by the scheduling logic).
- `HEIGHT`, 1080: rows per frame.
- `BUFFER_LINES`, 4: line-buffer slots. Elaboration error if `BUFFER_LINES < 2*REACH+1`.
- `REACH`, 1: maximum vertical distance, in rows, between an output row and any source row it samples.
- `COORD_WIDTH`, 16: row counter width.

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_start_in` in 1: pulse, first pixel of a frame accepted upstream (tuser&tvalid&tready).
- `in_line_done` in 1: pulse, last pixel of an input row written.
- `out_line_done` in 1: pulse, last pixel of the current output row emitted.
- `err_clr` in 1: pulse, clears `err_flags`.
- `wr_allow` out 1: input writer may accept pixels.
- `wr_line_idx` out clog2(BUFFER_LINES): slot receiving the current input row.
- `rd_go` out 1: remapper may produce row `rd_row`.
- `rd_row` out COORD_WIDTH: current output row.
- `rd_oldest_row` out COORD_WIDTH: oldest resident input row.
- `rd_oldest_idx` out clog2(BUFFER_LINES): slot holding `rd_oldest_row`.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `busy` out 1: state is not IDLE.
- `err_flags` out 3: sticky error bits. Bit 0 = SOF mid-frame, bit 1 = input overrun, bit 2 = output underrun.

## Operation
- Internal counter `lines_in` (0..HEIGHT) counts rows written this frame; `oldest_row` counts rows evicted.
- States:
  - IDLE: `wr_allow=1`. On `frame_start_in`: zero all counters and indices, go to ACTIVE.
  - ACTIVE: `wr_allow = (lines_in < oldest_row + BUFFER_LINES)`. When `lines_in` reaches HEIGHT, go to DRAIN.
  - DRAIN: `wr_allow=0`. When `out_line_done` completes row HEIGHT-1, go to DONE.
  - DONE: `frame_done=1` for one cycle, then go to IDLE. On entering IDLE, `rd_row` = 0.
- `rd_go = 1` in ACTIVE/DRAIN when `lines_in >= min(rd_row+REACH+1, HEIGHT)`. Compute the sum at COORD_WIDTH+1 bits with no wrap.
- `in_line_done` accepted (ACTIVE, `wr_allow=1`, `lines_in<HEIGHT`):
  - `lines_in += 1`.
  - `wr_line_idx` increments, wrapping from BUFFER_LINES-1 to 0.
- `out_line_done` accepted (`rd_go=1`):
  - `rd_row += 1`.
  - `oldest_row <= max(oldest_row, rd_row+1-REACH)`, clipped at 0 and at `lines_in`.
  - `rd_oldest_idx` advances by the same amount, wrapping. The advance is at most 1 per event when `REACH>=1`.
- Datapath slot for source row y = (`rd_oldest_idx` + y − `rd_oldest_row`) wrapped to BUFFER_LINES. The datapath computes this; the scheduler guarantees y lies in [`rd_oldest_row`, `lines_in`−1].
- Simultaneous `in_line_done` and `out_line_done`: both are applied in the same cycle. `wr_allow` uses the post-update `oldest_row`.
- Errors and their effects:
  - `frame_start_in` in ACTIVE/DRAIN/DONE: set `err[0]`, restart the frame (counters zeroed, ACTIVE).
  - `in_line_done` not accepted: set `err[1]`, counters unchanged.
  - `out_line_done` with `rd_go=0`: set `err[2]`, `rd_row` unchanged.
  - `err_clr` and a new error in the same cycle: the new error wins.
- `rst` at any point, mid-frame included, returns to IDLE and clears all counters and flags. There is no partial-frame recovery.

## Timing
- All outputs are registered. Each input pulse sampled at edge N is reflected in every output from edge N+1.
- Reset values:
  - `wr_allow=0`, `rd_go=0`, `frame_done=0`, `busy=0`, `err_flags=0`.
  - All indices and rows 0.
  - First cycle after `rst` deasserts: `wr_allow=1`.
- `rd_go` falls in the same cycle `rd_row` increments if the next row's lines are not yet present. There is no bubble when they are.
- DONE lasts exactly one cycle. A `frame_start_in` during DONE is flagged as an error and restarts the frame (per the error rules above).

## Test plan
- Reset then idle → all outputs at their reset values, `wr_allow=1` one cycle after `rst` falls, `busy=0`.
- HEIGHT=6, BL=4, REACH=1:
  - Fill: SOF, one `in_line_done` → `rd_go=0`; second `in_line_done` → `rd_go=1`, `rd_row=0`, `wr_line_idx=2`.
- Backpressure: four `in_line_done`, no outputs → `wr_allow=0`. First `out_line_done` → still 0 (`oldest_row=0`). Second → `oldest_row=1`, `rd_oldest_idx=1`, `wr_allow=1`.
- Full frame, interleaved: six input and six output rows → DRAIN after the sixth input row; `frame_done` pulses one cycle after the sixth `out_line_done`, then `busy=0` and `rd_row=0`.
- Same-cycle `in_line_done` and `out_line_done` with buffer full → `lines_in` and `oldest_row` both increment; `wr_allow` stays 1.
- Error cases:
  - SOF mid-frame → `err=001`, counters zeroed, ACTIVE.
  - `out_line_done` while `rd_go=0` → `err=101`, `rd_row` unchanged.
  - `err_clr` → `err=000`.
